// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port-A arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_LD
  } owner_e;

  localparam int unsigned DEFAULT_MAX_WAIT = 4;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Arbitrates data-memory port A between the MEM stage and the external loader;
// the CPU has priority, and a bounded wait counter forces occasional loader grants.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_valid,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ready,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  input  logic              ld_excl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_q, wait_d;
  logic       ld_last_q, ld_last_d;
  logic       rd_pend_q, rd_pend_d;
  logic       force_win;
  logic       gnt_ld, gnt_cpu;
  owner_e     owner;

  // Grants are qualified by rst so nothing reaches the memory while in reset.
  assign force_win = (wait_q == WAIT_MAX);
  assign gnt_ld    = rst & ld_valid & (ld_excl | ~cpu_req | (force_win & ~ld_last_q));
  assign gnt_cpu   = rst & cpu_req & ~gnt_ld;

  always_comb begin
    owner = OWN_NONE;
    if (gnt_ld) begin
      owner = OWN_LD;
    end else if (gnt_cpu) begin
      owner = OWN_CPU;
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wren  = 1'b0;
    case (owner)
      OWN_LD: begin
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
        mem_wren  = ld_we;
      end
      OWN_CPU: begin
        mem_wren = cpu_we;
      end
      default: ;
    endcase
  end

  assign ld_ready  = gnt_ld;
  assign cpu_stall = cpu_req & gnt_ld;
  assign cpu_rdata = mem_q;
  assign ld_rdata  = mem_q;
  assign ld_rvalid = rd_pend_q & rst;

  always_comb begin
    wait_d = wait_q;
    if (!ld_valid || gnt_ld) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // A stolen CPU slot blocks the next forced grant until the CPU has had a turn.
  always_comb begin
    ld_last_d = ld_last_q;
    if (gnt_ld && cpu_req) begin
      ld_last_d = 1'b1;
    end else if (gnt_cpu) begin
      ld_last_d = 1'b0;
    end
  end

  assign rd_pend_d = gnt_ld & ~ld_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q    <= '0;
      ld_last_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      ld_last_q <= ld_last_d;
      rd_pend_q <= rd_pend_d;
    end
  end

endmodule
